// File: rtl/data_bus_arbiter.sv
// Purpose: round-robin arbiter sharing one data memory port between m0 (LSU) and m1 (debug/DMA).
// Latency: zero-cycle request/grant and response paths; only busy_o and rvalid_err_o are registered.
// Backpressure: a master stalls until granted; requests stop while MAX_OUTST responses are outstanding.
//
// Ports:
//   clk, rst_n                      clock (rising edge), async active-low reset
//   m0_* / m1_*                     master req/gnt/addr/we/be/wdata/rvalid/rdata
//   data_*                          memory-side req/gnt/addr/we/be/wdata/rvalid/rdata
//   busy_o                          one or more transactions outstanding
//   rvalid_err_o                    one-cycle pulse: rvalid arrived with nothing outstanding
module data_bus_arbiter #(
    parameter int MAX_OUTST = 2
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        m0_req_i,
    output logic        m0_gnt_o,
    input  logic [31:0] m0_addr_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_be_i,
    input  logic [31:0] m0_wdata_i,
    output logic        m0_rvalid_o,
    output logic [31:0] m0_rdata_o,

    input  logic        m1_req_i,
    output logic        m1_gnt_o,
    input  logic [31:0] m1_addr_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_be_i,
    input  logic [31:0] m1_wdata_i,
    output logic        m1_rvalid_o,
    output logic [31:0] m1_rdata_o,

    output logic        data_req_o,
    input  logic        data_gnt_i,
    output logic [31:0] data_addr_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i,

    output logic        busy_o,
    output logic        rvalid_err_o
);

    localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int CNT_W = $clog2(MAX_OUTST + 1);

    // Owner FIFO: one bit per outstanding transaction naming the master that issued it.
    logic [MAX_OUTST-1:0] owner_q, owner_d;
    logic [PTR_W-1:0]     wptr_q, wptr_d;
    logic [PTR_W-1:0]     rptr_q, rptr_d;
    logic [CNT_W-1:0]     count_q, count_d;

    logic rr_last_q, rr_last_d;
    logic lock_vld_q, lock_vld_d;
    logic lock_id_q, lock_id_d;
    logic rvalid_err_q, rvalid_err_d;

    logic sel;
    logic sel_req;
    logic full;
    logic accept;
    logic pop;
    logic head;

    // Selection: a held lock wins, then a lone requester, then round-robin on a tie.
    always_comb begin
        sel = 1'b0;
        if (lock_vld_q) begin
            sel = lock_id_q;
        end else if (m0_req_i && m1_req_i) begin
            sel = ~rr_last_q;
        end else if (m1_req_i) begin
            sel = 1'b1;
        end
    end

    assign sel_req = sel ? m1_req_i : m0_req_i;
    // Full is taken from the registered count, so a same-cycle pop never enables a push.
    assign full    = (count_q == CNT_W'(MAX_OUTST));

    assign data_req_o   = sel_req & ~full;
    assign data_addr_o  = sel ? m1_addr_i  : m0_addr_i;
    assign data_we_o    = sel ? m1_we_i    : m0_we_i;
    assign data_be_o    = sel ? m1_be_i    : m0_be_i;
    assign data_wdata_o = sel ? m1_wdata_i : m0_wdata_i;

    assign accept   = data_req_o & data_gnt_i;
    assign m0_gnt_o = accept & ~sel;
    assign m1_gnt_o = accept & sel;

    // Responses return in accept order, so the FIFO head names the owner.
    assign pop         = data_rvalid_i & (count_q != '0);
    assign head        = owner_q[rptr_q];
    assign m0_rvalid_o = pop & ~head;
    assign m1_rvalid_o = pop & head;
    assign m0_rdata_o  = data_rdata_i;
    assign m1_rdata_o  = data_rdata_i;

    assign busy_o       = (count_q != '0);
    assign rvalid_err_o = rvalid_err_q;

    always_comb begin
        owner_d      = owner_q;
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        count_d      = count_q;
        rr_last_d    = rr_last_q;
        lock_vld_d   = lock_vld_q;
        lock_id_d    = lock_id_q;
        rvalid_err_d = data_rvalid_i & (count_q == '0);

        if (accept) begin
            owner_d[wptr_q] = sel;
            wptr_d          = (wptr_q == PTR_W'(MAX_OUTST - 1)) ? '0 : wptr_q + 1'b1;
            rr_last_d       = sel;
        end
        if (pop) begin
            rptr_d = (rptr_q == PTR_W'(MAX_OUTST - 1)) ? '0 : rptr_q + 1'b1;
        end

        unique case ({accept, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Hold the selected master while its request waits (memory stall or full FIFO);
        // drop the lock on accept or if the master withdraws its request.
        if (sel_req && !accept) begin
            lock_vld_d = 1'b1;
            lock_id_d  = sel;
        end else begin
            lock_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q      <= '0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
            rr_last_q    <= 1'b1;
            lock_vld_q   <= 1'b0;
            lock_id_q    <= 1'b0;
            rvalid_err_q <= 1'b0;
        end else begin
            owner_q      <= owner_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            count_q      <= count_d;
            rr_last_q    <= rr_last_d;
            lock_vld_q   <= lock_vld_d;
            lock_id_q    <= lock_id_d;
            rvalid_err_q <= rvalid_err_d;
        end
    end

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Purpose: self-checking bench for data_bus_arbiter (table vectors, corner sequences, random vs model).
// Latency: one stimulus cycle per step; combinational outputs sampled on the falling edge.
// Backpressure: memory grant and rvalid are driven directly by the stimulus.
module tb_data_bus_arbiter;

    localparam int MAX = 2;

    logic        clk;
    logic        rst_n;
    logic        m0_req, m0_gnt, m0_we, m0_rvalid;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic [3:0]  m0_be;
    logic        m1_req, m1_gnt, m1_we, m1_rvalid;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m1_be;
    logic        data_req, data_gnt, data_we, data_rvalid;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [3:0]  data_be;
    logic        busy, rvalid_err;

    data_bus_arbiter #(.MAX_OUTST(MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req_i(m0_req), .m0_gnt_o(m0_gnt), .m0_addr_i(m0_addr), .m0_we_i(m0_we),
        .m0_be_i(m0_be), .m0_wdata_i(m0_wdata), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
        .m1_req_i(m1_req), .m1_gnt_o(m1_gnt), .m1_addr_i(m1_addr), .m1_we_i(m1_we),
        .m1_be_i(m1_be), .m1_wdata_i(m1_wdata), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
        .data_req_o(data_req), .data_gnt_i(data_gnt), .data_addr_o(data_addr), .data_we_o(data_we),
        .data_be_o(data_be), .data_wdata_o(data_wdata), .data_rvalid_i(data_rvalid),
        .data_rdata_i(data_rdata), .busy_o(busy), .rvalid_err_o(rvalid_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: queue of owners in accept order, last winner, and the master being held.
    bit own_q[$];
    bit m_rr_last;
    bit m_hold_vld;
    bit m_hold_id;
    bit m_err;

    // Values sampled from the DUT in the most recent step.
    logic        s_dreq, s_g0, s_g1, s_rv0, s_rv1, s_busy, s_err;
    logic [31:0] s_addr, s_rd0, s_rd1;

    typedef struct {
        logic [3:0]  stim;   // {m0_req, m1_req, data_gnt, data_rvalid}
        logic [6:0]  expv;   // {data_req, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, busy, rvalid_err}
        logic [31:0] addr;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        own_q.delete();
        m_rr_last  = 1'b1;
        m_hold_vld = 1'b0;
        m_hold_id  = 1'b0;
        m_err      = 1'b0;
    endtask

    // Drive one cycle, compare against the model before the edge, then advance the model.
    task automatic step(input logic r0, input logic r1, input logic gnt, input logic rv,
                        input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] rd);
        bit          sel, sreq, full, dreq, acc, pop, head;
        logic [31:0] e_addr, e_wdata;
        logic        e_we;
        logic [3:0]  e_be;
        m0_req = r0; m0_addr = a0; m0_we = a0[0]; m0_be = a0[7:4]; m0_wdata = ~a0;
        m1_req = r1; m1_addr = a1; m1_we = a1[0]; m1_be = a1[7:4]; m1_wdata = ~a1;
        data_gnt = gnt; data_rvalid = rv; data_rdata = rd;
        @(negedge clk);

        if (m_hold_vld)    sel = m_hold_id;
        else if (r0 && r1) sel = ~m_rr_last;
        else               sel = r1;
        sreq    = sel ? r1 : r0;
        full    = (own_q.size() == MAX);
        dreq    = sreq && !full;
        acc     = dreq && gnt;
        pop     = rv && (own_q.size() != 0);
        head    = (own_q.size() != 0) ? own_q[0] : 1'b0;
        e_addr  = sel ? a1 : a0;
        e_we    = e_addr[0];
        e_be    = e_addr[7:4];
        e_wdata = ~e_addr;

        s_dreq = data_req; s_g0 = m0_gnt; s_g1 = m1_gnt; s_rv0 = m0_rvalid; s_rv1 = m1_rvalid;
        s_busy = busy; s_err = rvalid_err; s_addr = data_addr; s_rd0 = m0_rdata; s_rd1 = m1_rdata;

        chk("data_req", {31'd0, data_req}, {31'd0, dreq});
        chk("m0_gnt", {31'd0, m0_gnt}, {31'd0, acc && !sel});
        chk("m1_gnt", {31'd0, m1_gnt}, {31'd0, acc && sel});
        chk("m0_rvalid", {31'd0, m0_rvalid}, {31'd0, pop && !head});
        chk("m1_rvalid", {31'd0, m1_rvalid}, {31'd0, pop && head});
        chk("data_addr", data_addr, e_addr);
        chk("data_we", {31'd0, data_we}, {31'd0, e_we});
        chk("data_be", {28'd0, data_be}, {28'd0, e_be});
        chk("data_wdata", data_wdata, e_wdata);
        chk("m0_rdata", m0_rdata, rd);
        chk("m1_rdata", m1_rdata, rd);
        chk("busy", {31'd0, busy}, {31'd0, own_q.size() != 0});
        chk("rvalid_err", {31'd0, rvalid_err}, {31'd0, m_err});

        m_err = rv && (own_q.size() == 0);
        if (pop) void'(own_q.pop_front());
        if (acc) begin
            own_q.push_back(sel);
            m_rr_last = sel;
        end
        m_hold_vld = sreq && !acc;
        m_hold_id  = sel;

        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = '{4'b1110, 7'b1100000, 32'hA0};
        tbl[1]  = '{4'b1111, 7'b1011010, 32'hB0};
        tbl[2]  = '{4'b1111, 7'b1100110, 32'hA0};
        tbl[3]  = '{4'b1111, 7'b1011010, 32'hB0};
        tbl[4]  = '{4'b0001, 7'b0000110, 32'hA0};
        tbl[5]  = '{4'b0001, 7'b0000000, 32'hA0};
        tbl[6]  = '{4'b0000, 7'b0000001, 32'hA0};
        tbl[7]  = '{4'b0000, 7'b0000000, 32'hA0};
        tbl[8]  = '{4'b1010, 7'b1100000, 32'hA0};
        tbl[9]  = '{4'b1010, 7'b1100010, 32'hA0};
        tbl[10] = '{4'b1010, 7'b0000010, 32'hA0};
        tbl[11] = '{4'b1011, 7'b0001010, 32'hA0};
        tbl[12] = '{4'b1010, 7'b1100010, 32'hA0};
        tbl[13] = '{4'b0001, 7'b0001010, 32'hA0};
        tbl[14] = '{4'b0001, 7'b0001010, 32'hA0};
        tbl[15] = '{4'b0000, 7'b0000000, 32'hA0};

        rst_n = 1'b0;
        m0_req = 0; m0_addr = 0; m0_we = 0; m0_be = 0; m0_wdata = 0;
        m1_req = 0; m1_addr = 0; m1_we = 0; m1_be = 0; m1_wdata = 0;
        data_gnt = 0; data_rvalid = 0; data_rdata = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_err", {31'd0, rvalid_err}, 32'd0);
        chk("reset_req", {31'd0, data_req}, 32'd0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table: round-robin tie, in-order routing, spurious rvalid, full stall.
        for (int i = 0; i < 16; i++) begin
            step(tbl[i].stim[3], tbl[i].stim[2], tbl[i].stim[1], tbl[i].stim[0],
                 32'hA0, 32'hB0, 32'h1000 + i);
            chk($sformatf("tbl%0d_outs", i),
                {25'd0, s_dreq, s_g0, s_g1, s_rv0, s_rv1, s_busy, s_err}, {25'd0, tbl[i].expv});
            chk($sformatf("tbl%0d_addr", i), s_addr, tbl[i].addr);
        end

        // Lock: make m1 the last winner so an unlocked tie would pick m0.
        step(0, 1, 1, 0, 32'h200, 32'h100, 0);
        step(0, 0, 0, 1, 32'h200, 32'h100, 0);
        step(0, 1, 0, 0, 32'h200, 32'h100, 0);
        chk("lock_c1_addr", s_addr, 32'h100);
        step(1, 1, 0, 0, 32'h200, 32'h100, 0);
        chk("lock_c2_addr", s_addr, 32'h100);
        step(1, 1, 0, 0, 32'h200, 32'h100, 0);
        chk("lock_c3_addr", s_addr, 32'h100);
        step(1, 1, 1, 0, 32'h200, 32'h100, 0);
        chk("lock_c4_addr", s_addr, 32'h100);
        chk("lock_c4_g1", {31'd0, s_g1}, 32'd1);
        step(1, 1, 1, 0, 32'h200, 32'h100, 0);
        chk("lock_c5_g0", {31'd0, s_g0}, 32'd1);
        step(0, 0, 0, 1, 32'h200, 32'h100, 0);
        step(0, 0, 0, 1, 32'h200, 32'h100, 0);

        // Push and pop in the same cycle at count=1.
        step(1, 0, 1, 0, 32'h300, 32'h310, 0);
        step(0, 1, 1, 1, 32'h300, 32'h310, 32'hDEADBEEF);
        chk("pp_rv0", {31'd0, s_rv0}, 32'd1);
        chk("pp_rv1", {31'd0, s_rv1}, 32'd0);
        chk("pp_g1", {31'd0, s_g1}, 32'd1);
        chk("pp_rd0", s_rd0, 32'hDEADBEEF);
        chk("pp_rd1", s_rd1, 32'hDEADBEEF);
        step(0, 0, 0, 0, 32'h300, 32'h310, 0);
        chk("pp_busy", {31'd0, s_busy}, 32'd1);
        step(0, 0, 0, 1, 32'h300, 32'h310, 0);
        chk("pp_drain_rv1", {31'd0, s_rv1}, 32'd1);

        // Asynchronous reset with two transactions outstanding.
        step(1, 0, 1, 0, 32'h400, 32'h410, 0);
        step(0, 1, 1, 0, 32'h400, 32'h410, 0);
        m0_req = 0; m1_req = 0; data_gnt = 1; data_rvalid = 1;
        #1 rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_gnt", {30'd0, m0_gnt, m1_gnt}, 32'd0);
        chk("arst_rvalid", {30'd0, m0_rvalid, m1_rvalid}, 32'd0);
        chk("arst_req", {31'd0, data_req}, 32'd0);
        model_reset();
        data_rvalid = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(0, 0, 0, 1, 32'h400, 32'h410, 0);
        step(1, 1, 1, 0, 32'h400, 32'h410, 0);
        chk("post_rst_g0", {31'd0, s_g0}, 32'd1);
        chk("post_rst_err", {31'd0, s_err}, 32'd1);
        step(0, 0, 0, 1, 32'h400, 32'h410, 0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) == 0),
                 $urandom, $urandom, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
